// File: rtl/ad9244_to_axis_m.sv
// AD9244 capture front end: ADC clock generation, sample formatting, sample FIFO
// and AXI4-Stream master output with framed tlast and a registered status word.

// Generic FIFO: head is presented combinationally on rdat_o.
// Latency: a written word becomes visible at the head one cycle later.
// Backpressure: caller must not write when full unless it also reads that cycle.
module ad9244_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_i,
  input  logic [W-1:0]               wdat_i,
  input  logic                       rd_i,
  output logic [W-1:0]               rdat_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);
  localparam logic [LW-1:0] CNT_FULL = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_i && !rd_i)
      cnt_d = cnt_q + CNT_ONE;
    else if (rd_i && !wr_i)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_i) wptr_q <= wptr_q + PTR_ONE;
      if (rd_i) rptr_q <= rptr_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_i) mem_q[wptr_q] <= wdat_i;
  end

  assign rdat_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign level_o = cnt_q;
endmodule

// AD9244 capture to AXI4-Stream master.
// Latency: FIFO write 1 cycle after the sample strobe, tvalid 2 cycles after it.
// Backpressure: tready low holds the output word; a full FIFO drops and counts samples.
module ad9244_to_axis_m #(
  parameter int CLK_DIV    = 1,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  output logic        ClockToADC,
  input  logic [14:0] ADCdata,
  input  logic [3:0]  control,
  output logic [31:0] status,
  output logic        m00_axis_tvalid,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tstrb,
  output logic        m00_axis_tlast,
  input  logic        m00_axis_tready
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] FRM_ONE  = FW'(1);

  logic clk, rst;
  assign clk = m00_axis_aclk;
  assign rst = m00_axis_aresetn;

  logic [DW-1:0] div_q, div_d;
  logic          adc_clk_q, adc_clk_d;
  logic          tick, strobe;
  logic [13:0]   ramp_q;
  logic          cap_vld_q;
  logic [16:0]   cap_dat_q;
  logic [14:0]   seq_q, seq_d;
  logic          out_vld_q;
  logic [31:0]   out_dat_q;
  logic [FW-1:0] frame_q, frame_d;
  logic [15:0]   ovf_q, ovf_d;
  logic          sticky_q, sticky_d;
  logic [31:0]   status_q;

  logic [13:0]   raw14, s14;
  logic [15:0]   s16;
  logic          otr;

  logic          fifo_wr, fifo_rd, fifo_empty, fifo_full, drop, xfer;
  logic [31:0]   fifo_rdat;
  logic [AW:0]   fifo_level;
  logic [4:0]    lvl5;

  // Strobe on the edge where the ADC clock register falls, i.e. mid ADC period.
  assign tick   = (div_q == DIV_LAST);
  assign strobe = tick && adc_clk_q;

  always_comb begin
    div_d     = div_q + DIV_ONE;
    adc_clk_d = adc_clk_q;
    if (tick) begin
      div_d     = '0;
      adc_clk_d = ~adc_clk_q;
    end
  end

  // Offset-binary to two's complement is an MSB flip followed by sign extension.
  always_comb begin
    raw14 = control[1] ? ramp_q : ADCdata[13:0];
    otr   = ADCdata[14] && !control[1];
    s14   = control[3] ? {~raw14[13], raw14[12:0]} : raw14;
    s16   = control[3] ? {{2{s14[13]}}, s14} : {2'b00, s14};
  end

  assign xfer    = out_vld_q && m00_axis_tready;
  assign fifo_rd = !fifo_empty && (!out_vld_q || m00_axis_tready);
  assign fifo_wr = cap_vld_q && (!fifo_full || fifo_rd);
  assign drop    = cap_vld_q && fifo_full && !fifo_rd;

  always_comb begin
    seq_d    = fifo_wr ? seq_q + 15'd1 : seq_q;
    frame_d  = frame_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    if (xfer)
      frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + FRM_ONE;
    if (control[2]) begin
      ovf_d    = '0;
      sticky_d = 1'b0;
    end else if (drop) begin
      sticky_d = 1'b1;
      if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end
  end

  ad9244_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_i    (fifo_wr),
    .wdat_i  ({seq_q, cap_dat_q}),
    .rd_i    (fifo_rd),
    .rdat_o  (fifo_rdat),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign lvl5 = 5'(fifo_level);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      adc_clk_q <= 1'b0;
      ramp_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_dat_q <= '0;
      seq_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      frame_q   <= '0;
      ovf_q     <= '0;
      sticky_q  <= 1'b0;
      status_q  <= '0;
    end else begin
      div_q     <= div_d;
      adc_clk_q <= adc_clk_d;
      cap_vld_q <= strobe && control[0];
      if (strobe) begin
        ramp_q    <= ramp_q + 14'd1;
        cap_dat_q <= {otr, s16};
      end
      seq_q <= seq_d;
      if (fifo_rd) begin
        out_vld_q <= 1'b1;
        out_dat_q <= fifo_rdat;
      end else if (xfer) begin
        out_vld_q <= 1'b0;
      end
      frame_q  <= frame_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      status_q <= {7'd0, lvl5, sticky_q, fifo_full, fifo_empty, control[0], ovf_q};
    end
  end

  assign ClockToADC      = adc_clk_q;
  assign status          = status_q;
  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tdata  = out_dat_q;
  assign m00_axis_tstrb  = 4'hF;
  assign m00_axis_tlast  = out_vld_q && (frame_q == FRM_LAST);
endmodule

// File: tb/tb_ad9244_to_axis_m.sv
// Self-checking bench for ad9244_to_axis_m: random ADC data against a sample-queue model.
`timescale 1ns/1ps
module tb_ad9244_to_axis_m;
  localparam int CLK_DIV    = 1;
  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_clk;
  logic [14:0] adc_data;
  logic [3:0]  control;
  logic [31:0] status;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;

  ad9244_to_axis_m #(.CLK_DIV(CLK_DIV), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst),
    .ClockToADC       (adc_clk),
    .ADCdata          (adc_data),
    .control          (control),
    .status           (status),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tdata   (tdata),
    .m00_axis_tstrb   (tstrb),
    .m00_axis_tlast   (tlast),
    .m00_axis_tready  (tready)
  );

  always #12.5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state: edges since reset release, ramp value, captured samples in order.
  int          n = 0;
  logic [13:0] ramp_m = '0;
  logic [16:0] capq[$];
  int          xfer_k = 0;
  int          first_n = -1;
  int          drops = 0;
  bit          drop_win = 1'b0;
  logic        s_vld = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_dat = '0;
  logic [31:0] last_word = '0;

  function automatic int adc_at(input int k);
    return (k / CLK_DIV) % 2;
  endfunction

  function automatic logic [16:0] fmt(input logic [14:0] raw, input logic [3:0] c, input logic [13:0] rmp);
    int   v;
    logic o;
    v = c[1] ? int'(rmp) : int'(raw[13:0]);
    o = c[1] ? 1'b0 : raw[14];
    if (c[3]) v = v - 8192;
    return {o, 16'(v)};
  endfunction

  task automatic score(input logic [31:0] d, input logic l);
    int j;
    logic [16:0] tmp;
    check("seq", {17'd0, d[31:17]}, 32'(xfer_k % 32768));
    check("tlast", {31'd0, l}, ((xfer_k % FRAME_LEN) == FRAME_LEN - 1) ? 32'd1 : 32'd0);
    if (capq.size() == 0) begin
      check("data_unexpected", 32'd1, 32'd0);
    end else if (!drop_win) begin
      tmp = capq.pop_front();
      check("data", {15'd0, d[16:0]}, {15'd0, tmp});
    end else begin
      j = -1;
      for (int i = 0; i < capq.size(); i++)
        if (j < 0 && capq[i] == d[16:0]) j = i;
      check("data_in_order", (j >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (j >= 0) begin
        drops += j;
        for (int i = 0; i <= j; i++) tmp = capq.pop_front();
      end
    end
    last_word = d;
    xfer_k++;
  endtask

  task automatic step();
    logic pv, pr, pl;
    logic [31:0] pd;
    pv = s_vld; pr = tready; pd = s_dat; pl = s_last;
    @(posedge clk);
    if (rst) begin
      n = 0; ramp_m = '0; capq.delete(); xfer_k = 0; first_n = -1; drops = 0;
    end else begin
      n++;
      if (adc_at(n - 1) == 1 && adc_at(n) == 0) begin
        if (control[0]) begin
          capq.push_back(fmt(adc_data, control, ramp_m));
          if (first_n < 0) first_n = n;
        end
        ramp_m = ramp_m + 14'd1;
      end
      if (pv && pr) score(pd, pl);
    end
    #1;
    s_vld = tvalid; s_dat = tdata; s_last = tlast;
    check("adc_clk", {31'd0, adc_clk}, rst ? 32'd0 : 32'(adc_at(n)));
    check("tstrb", {28'd0, tstrb}, 32'hF);
    if (rst) begin
      check("rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_tdata", tdata, 32'd0);
      check("rst_tlast", {31'd0, tlast}, 32'd0);
      check("rst_status", status, 32'd0);
    end else if (pv && !pr) begin
      check("hold_vld", {31'd0, tvalid}, 32'd1);
      check("hold_dat", tdata, pd);
      check("hold_last", {31'd0, tlast}, {31'd0, pl});
    end
    if (!rst && first_n > 0) begin
      if (n == first_n + 1) check("lat_early", {31'd0, tvalid}, 32'd0);
      if (n == first_n + 2) check("lat_rise", {31'd0, tvalid}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; control = 4'b0000; adc_data = '0; tready = 1'b0;
    repeat (4) step();

    // Ramp input, one increment per ADC clock, continuous ready.
    rst = 1'b0; control = 4'b0001; tready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      adc_data = 15'(n / (2 * CLK_DIV));
    end

    // Random data, random backpressure, occasional format/test-pattern changes.
    for (int i = 0; i < 600; i++) begin
      step();
      adc_data = 15'($urandom);
      tready   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 49) == 0) control[3] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 79) == 0) control[1] = 1'($urandom_range(0, 1));
    end

    // Long stall: FIFO fills, later samples drop and are counted.
    control = 4'b0001; tready = 1'b1;
    repeat (20) step();
    drop_win = 1'b1; tready = 1'b0;
    repeat (40) begin
      step();
      adc_data = 15'($urandom);
    end
    check("st_full", {31'd0, status[18]}, 32'd1);
    check("st_level", {27'd0, status[24:20]}, 32'd16);
    check("st_sticky", {31'd0, status[19]}, 32'd1);
    check("st_ovf_nz", (status[15:0] != 16'd0) ? 32'd1 : 32'd0, 32'd1);
    check("st_en", {31'd0, status[16]}, 32'd1);
    tready = 1'b1;
    repeat (60) step();
    control[0] = 1'b0;
    repeat (40) step();
    check("drain_empty", {31'd0, status[17]}, 32'd1);
    check("drain_en", {31'd0, status[16]}, 32'd0);
    check("drain_left", 32'(capq.size()), 32'd0);
    check("ovf_cnt", {16'd0, status[15:0]}, 32'(drops));
    drop_win = 1'b0;

    control[2] = 1'b1; step();
    control[2] = 1'b0; step();
    check("clr_cnt", {16'd0, status[15:0]}, 32'd0);
    check("clr_sticky", {31'd0, status[19]}, 32'd0);

    // Two's-complement format, OTR flag, test pattern.
    control = 4'b1001; adc_data = 15'h0000;
    repeat (20) step();
    check("fmt_e000", {16'd0, last_word[15:0]}, 32'h0000_E000);
    check("fmt_otr0", {31'd0, last_word[16]}, 32'd0);
    adc_data = 15'h4000;
    repeat (20) step();
    check("otr_set", {31'd0, last_word[16]}, 32'd1);
    check("otr_s16", {16'd0, last_word[15:0]}, 32'h0000_E000);
    control = 4'b1011;
    repeat (20) step();
    check("tp_otr", {31'd0, last_word[16]}, 32'd0);

    // Reset mid-frame with samples queued; seq and frame restart afterwards.
    control = 4'b0001;
    repeat (9) step();
    tready = 1'b0;
    repeat (12) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0; tready = 1'b1;
    repeat (40) step();
    check("post_rst_words", (xfer_k >= 8) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
